ir_regfile_loader: RTL and testbench
====================================

# ir_regfile_loader

Parametrised instruction register file with a built-in loader. After reset it clears its storage, then on command fetches `DEPTH` consecutive instruction words from a memory device over a req/ack handshake. Once loaded it serves single-cycle-latency reads, and optional writes, to the core. It is the next-generation replacement for the fixed-size instruction register file between the memory interface and the instruction decode stage.

## Interface

**Parameters**
- `DATA_WIDTH`, default 16: instruction word, device ID and address width.
- `DEPTH`, default 16: number of entries; power of two, ≥ 2.
- `ADDR_WIDTH`, default 4: entry index width, equal to log2(`DEPTH`).

**Ports**
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `i_load_start` in 1: one-cycle pulse that starts a load.
- `i_device` in `DATA_WIDTH`: memory device ID, sampled on `i_load_start`.
- `i_base_addr` in `DATA_WIDTH`: first memory address, sampled on `i_load_start`.
- `o_mem_req` out 1: memory read request.
- `o_mem_device` out `DATA_WIDTH`: latched device ID.
- `o_mem_addr` out `DATA_WIDTH`: current fetch address.
- `i_mem_ack` in 1: memory acknowledge; `i_mem_data` is valid in the same cycle.
- `i_mem_data` in `DATA_WIDTH`: fetched word.
- `o_ready` out 1: high in WORK.
- `o_busy` out 1: high in INIT or LOAD.
- `i_rd_en` in 1, `i_rd_addr` in `ADDR_WIDTH`: read request.
- `o_rd_data` out `DATA_WIDTH`, `o_rd_valid` out 1: read result.
- `i_wr_en` in 1, `i_wr_addr` in `ADDR_WIDTH`, `i_wr_data` in `DATA_WIDTH`: core write.
- `o_parity_err` out 1: parity error on the current read (present only with `IR_PARITY_EN`).

## Operation

**States:** INIT → IDLE → LOAD → WORK. WORK → LOAD is taken on `i_load_start`.

- **INIT**
  - Entered on reset.
  - Clear counter writes 0 to entry 0..`DEPTH`-1, one entry per cycle.
  - After `DEPTH` cycles → IDLE.
  - `i_load_start` is ignored in this state.
- **IDLE**
  - `i_load_start` latches `i_device` and `i_base_addr`, clears the fetch index, → LOAD.
- **LOAD**
  - `o_mem_req` = 1.
  - `o_mem_addr` = base + index, truncated to `DATA_WIDTH` (wraps modulo 2^`DATA_WIDTH`).
  - Every cycle with `i_mem_ack` = 1 writes `i_mem_data` to entry[index] and increments the index.
  - Ack on index `DEPTH`-1 → WORK. `o_mem_req` is 0 from the next cycle.
  - `i_load_start` during LOAD is ignored.
- **WORK**
  - Reads and writes are served.
  - `i_load_start` → LOAD. A write in the same cycle is still performed but is overwritten by the reload.
- **Reads**
  - In WORK only. In other states `o_rd_valid` = 0 and `o_rd_data` holds its last value.
- **Writes**
  - In WORK only; ignored elsewhere.
- **Read/write collision** (same cycle, same address): the read returns the old data.
- **Reset mid-LOAD:** the memory transfer is abandoned. `o_mem_req` drops the next cycle and the block restarts INIT.

## Timing

**Reset values:**
- `o_mem_req` = 0, `o_ready` = 0, `o_busy` = 1.
- `o_rd_valid` = 0, `o_rd_data` = 0.
- `o_mem_addr` = 0, `o_mem_device` = 0.
- `o_parity_err` = 0.

**INIT** lasts exactly `DEPTH` cycles after the reset release edge. `o_busy` is 1 throughout.

**LOAD handshake:**
- `o_mem_req` rises the cycle after `i_load_start`.
- `o_mem_addr` is stable while `i_mem_ack` = 0.
- The address advances the cycle after each ack. Back-to-back acks give one word per cycle.

**Read latency:** 1 cycle. `i_rd_en` at edge N → `o_rd_data`/`o_rd_valid` at edge N+1. `o_rd_valid` is a one-cycle pulse per request.

**Load duration:**
- Minimum `DEPTH`+1 cycles from `i_load_start` to `o_ready`.
- `o_ready` rises the cycle after the final ack.

## Configuration

**`IR_PARITY_EN`**
- **Defined:**
  - Each entry stores one extra even-parity bit, computed on load and on write.
  - On a read, `o_parity_err` = 1 alongside `o_rd_valid` if the stored parity mismatches the data.
  - INIT clears entries to data 0 with parity 0.
- **Undefined:**
  - No parity storage.
  - `o_parity_err` port is absent.

## Test plan

1. **Reset/INIT:** `rst_n` low 2 cycles, then high.
   - `o_busy` = 1 for exactly 16 cycles, then IDLE.
   - Reading entry 5 after a load of all-zero data returns 0x0000.
2. **Basic load:** `i_load_start` with `i_device`=0x0003, `i_base_addr`=0x0100, ack every cycle, data = 0xA000 + index.
   - `o_mem_addr` steps 0x0100..0x010F.
   - `o_ready` is high 17 cycles after start.
   - Read of entry 7 returns 0xA007 one cycle later.
3. **Stalled handshake:** ack only every third cycle.
   - `o_mem_addr` holds during stalls.
   - All 16 words are stored correctly.
   - Address wrap with base 0xFFF8: fetch addresses 0xFFF8..0xFFFF, then 0x0000..0x0007.
4. **WORK collision:** write 0x1234 and read entry 2 (old value 0xA002) in the same cycle.
   - `o_rd_data` = 0xA002.
   - The next read of entry 2 returns 0x1234.
5. **Reset mid-LOAD:** assert `rst_n` low after 5 acks.
   - `o_mem_req` = 0 next cycle.
   - INIT reruns; no stale data is readable.
6. **Parity (`IR_PARITY_EN`):** force-flip a stored bit in entry 4, then read entry 4.
   - `o_parity_err` = 1 together with `o_rd_valid`.
   - An unmodified entry reads with `o_parity_err` = 0.

Source files
------------

// File: rtl/ir_regfile_loader.sv
// ir_regfile_loader: instruction register file that clears itself, loads DEPTH words over req/ack, then serves reads/writes.
// Optional IR_PARITY_EN adds an even-parity bit per entry and the o_parity_err output.
module ir_regfile_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load_start,
    input  logic [DATA_WIDTH-1:0] i_device,
    input  logic [DATA_WIDTH-1:0] i_base_addr,
    output logic                  o_mem_req,
    output logic [DATA_WIDTH-1:0] o_mem_device,
    output logic [DATA_WIDTH-1:0] o_mem_addr,
    input  logic                  i_mem_ack,
    input  logic [DATA_WIDTH-1:0] i_mem_data,
    output logic                  o_ready,
    output logic                  o_busy,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_valid,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data
`ifdef IR_PARITY_EN
    ,
    output logic                  o_parity_err
`endif
);
`ifdef IR_PARITY_EN
    localparam int W = DATA_WIDTH + 1;
`else
    localparam int W = DATA_WIDTH;
`endif
    typedef enum logic [1:0] {INIT, IDLE, LOAD, WORK} state_t;
    state_t state, state_nx;
    logic [ADDR_WIDTH-1:0] clr, clr_nx, idx, idx_nx, wa;
    logic [DATA_WIDTH-1:0] dev, base, wdata;
    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] wd;
    logic start, last_clr, last_ack, we, rd;
    always_comb begin
        start    = i_load_start && (state == IDLE || state == WORK);
        last_clr = clr == ADDR_WIDTH'(DEPTH - 1);
        last_ack = i_mem_ack && idx == ADDR_WIDTH'(DEPTH - 1);
        state_nx = start ? LOAD :
                   (state == INIT && last_clr) ? IDLE :
                   (state == LOAD && last_ack) ? WORK : state;
        clr_nx   = state == INIT ? clr + ADDR_WIDTH'(1) : '0;
        idx_nx   = start ? '0 : (state == LOAD && i_mem_ack) ? idx + ADDR_WIDTH'(1) : idx;
        we       = state == INIT || (state == LOAD && i_mem_ack) || (state == WORK && i_wr_en);
        wa       = state == INIT ? clr : state == LOAD ? idx : i_wr_addr;
        wdata    = state == INIT ? '0 : state == LOAD ? i_mem_data : i_wr_data;
`ifdef IR_PARITY_EN
        wd       = {^wdata, wdata};
`else
        wd       = wdata;
`endif
        rd       = state == WORK && i_rd_en;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= INIT;
            clr   <= '0;
            idx   <= '0;
            dev   <= '0;
            base  <= '0;
        end else begin
            state <= state_nx;
            clr   <= clr_nx;
            idx   <= idx_nx;
            if (start) begin
                dev  <= i_device;
                base <= i_base_addr;
            end
        end
    end
    // Storage has no reset; INIT clears it, and writes are blocked while reset is held.
    always_ff @(posedge clk) begin
        if (rst_n && we) mem[wa] <= wd;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_rd_valid <= 1'b0;
            o_rd_data  <= '0;
        end else begin
            o_rd_valid <= rd;
            if (rd) o_rd_data <= mem[i_rd_addr][DATA_WIDTH-1:0];
        end
    end
`ifdef IR_PARITY_EN
    // Stored entry XORs to zero when intact.
    always_ff @(posedge clk) begin
        if (!rst_n) o_parity_err <= 1'b0;
        else o_parity_err <= rd && ^mem[i_rd_addr];
    end
`endif
    assign o_mem_req    = state == LOAD;
    assign o_mem_device = dev;
    assign o_mem_addr   = base + DATA_WIDTH'(idx);
    assign o_ready      = state == WORK;
    assign o_busy       = state == INIT || state == LOAD;
endmodule

// File: tb/tb_ir_regfile_loader.sv
// tb_ir_regfile_loader: directed bench for ir_regfile_loader with hand-computed expectations.
module tb_ir_regfile_loader;
    logic clk = 1'b0, rst_n = 1'b0;
    logic i_load_start = 1'b0, i_mem_ack = 1'b0, i_rd_en = 1'b0, i_wr_en = 1'b0;
    logic [15:0] i_device = '0, i_base_addr = '0, i_mem_data = '0, i_wr_data = '0;
    logic [3:0] i_rd_addr = '0, i_wr_addr = '0;
    logic o_mem_req, o_ready, o_busy, o_rd_valid;
    logic [15:0] o_mem_device, o_mem_addr, o_rd_data;
`ifdef IR_PARITY_EN
    logic o_parity_err;
`endif
    int n = 0, errs = 0, cyc = 0;

    always #5 clk = ~clk;

    ir_regfile_loader dut (
        .clk(clk), .rst_n(rst_n), .i_load_start(i_load_start), .i_device(i_device),
        .i_base_addr(i_base_addr), .o_mem_req(o_mem_req), .o_mem_device(o_mem_device),
        .o_mem_addr(o_mem_addr), .i_mem_ack(i_mem_ack), .i_mem_data(i_mem_data),
        .o_ready(o_ready), .o_busy(o_busy), .i_rd_en(i_rd_en), .i_rd_addr(i_rd_addr),
        .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .i_wr_en(i_wr_en),
        .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data)
`ifdef IR_PARITY_EN
        , .o_parity_err(o_parity_err)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_init(input string tag);
        int c = 0;
        do begin
            i_load_start = c == 3;
            tick;
            c++;
        end while (o_busy && c < 100);
        i_load_start = 1'b0;
        chk(tag, c, 16);
        chk({tag, "_req"}, o_mem_req, 0);
        chk({tag, "_ready"}, o_ready, 0);
    endtask

    task automatic do_load(input logic [15:0] dv, input logic [15:0] ba, input logic [15:0] db,
                           input int gap, input bit cst, output int cycles);
        int k = 0, c = 0;
        i_device = dv;
        i_base_addr = ba;
        i_load_start = 1'b1;
        tick;
        i_load_start = 1'b0;
        i_wr_en = 1'b0;
        cycles = 1;
        chk("req_rise", o_mem_req, 1);
        chk("mem_device", o_mem_device, dv);
        while (k < 16 && c < 200) begin
            chk("mem_addr", o_mem_addr, 32'(16'(ba + 16'(k))));
            i_load_start = c == 4;
            i_base_addr = c == 4 ? 16'h5555 : ba;
            i_mem_ack = (c % gap) == gap - 1;
            i_mem_data = cst ? db : 16'(db + 16'(k));
            tick;
            if (i_mem_ack) k++;
            c++;
            cycles++;
        end
        i_mem_ack = 1'b0;
        i_load_start = 1'b0;
        chk("ready_after_load", o_ready, 1);
        chk("req_drop", o_mem_req, 0);
    endtask

    task automatic rd(input logic [3:0] a, input logic [15:0] e, input string tag);
        i_rd_en = 1'b1;
        i_rd_addr = a;
        tick;
        i_rd_en = 1'b0;
        chk({tag, "_valid"}, o_rd_valid, 1);
        chk(tag, o_rd_data, e);
    endtask

    initial begin
        tick;
        tick;
        chk("rst_busy", o_busy, 1);
        chk("rst_req", o_mem_req, 0);
        chk("rst_ready", o_ready, 0);
        chk("rst_valid", o_rd_valid, 0);
        chk("rst_rdata", o_rd_data, 0);
        chk("rst_addr", o_mem_addr, 0);
        chk("rst_dev", o_mem_device, 0);
        rst_n = 1'b1;
        wait_init("init_len");
        i_rd_en = 1'b1;
        i_rd_addr = 4'd1;
        tick;
        i_rd_en = 1'b0;
        chk("idle_rd_valid", o_rd_valid, 0);
        chk("idle_rd_hold", o_rd_data, 0);

        do_load(16'h0003, 16'h0100, 16'hA000, 1, 1'b0, cyc);
        chk("load_cycles", cyc, 17);
        rd(4'd7, 16'hA007, "rd7");
        tick;
        chk("valid_pulse", o_rd_valid, 0);
        rd(4'd0, 16'hA000, "rd0");
        rd(4'd15, 16'hA00F, "rd15");

        i_wr_en = 1'b1;
        i_wr_addr = 4'd2;
        i_wr_data = 16'h1234;
        rd(4'd2, 16'hA002, "collide_old");
        i_wr_en = 1'b0;
        rd(4'd2, 16'h1234, "after_write");

        i_wr_en = 1'b1;
        i_wr_addr = 4'd3;
        i_wr_data = 16'hFFFF;
        do_load(16'h0007, 16'hFFF8, 16'hB000, 3, 1'b0, cyc);
        rd(4'd0, 16'hB000, "stall0");
        rd(4'd2, 16'hB002, "stall2");
        rd(4'd3, 16'hB003, "stall3");
        rd(4'd9, 16'hB009, "stall9");
        rd(4'd15, 16'hB00F, "stall15");

        i_device = 16'h0001;
        i_base_addr = 16'h0200;
        i_load_start = 1'b1;
        tick;
        i_load_start = 1'b0;
        i_mem_ack = 1'b1;
        i_mem_data = 16'hC0DE;
        repeat (5) tick;
        chk("midload_addr", o_mem_addr, 16'h0205);
        i_mem_ack = 1'b0;
        rst_n = 1'b0;
        tick;
        chk("midrst_req", o_mem_req, 0);
        chk("midrst_busy", o_busy, 1);
        rst_n = 1'b1;
        wait_init("reinit_len");
        do_load(16'h0002, 16'h0300, 16'h0000, 1, 1'b1, cyc);
        rd(4'd5, 16'h0000, "zero5");
        rd(4'd7, 16'h0000, "zero7");
`ifdef IR_PARITY_EN
        dut.mem[4] = dut.mem[4] ^ 17'h00001;
        rd(4'd4, 16'h0001, "par_rd4");
        chk("par_err4", o_parity_err, 1);
        rd(4'd5, 16'h0000, "par_rd5");
        chk("par_ok5", o_parity_err, 0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n, errs);
        $finish;
    end
endmodule
